bus_master_initiator: RTL

//  Initiator (master) end of the internal 32-bit register bus. Subsystems answer this bus through bus_FSM.

---
 rtl/bus_master_initiator.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bus_master_initiator.sv
// bus_master_initiator: initiator end of the internal register bus; one command runs a four-edge
// data/status handshake and returns a single response. Optional watchdog: define BUS_TIMEOUT_EN.
module bus_master_initiator #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_RW,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0] rsp_status,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] bus_reg_address,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  bus_RW,
    output logic                  bus_handshake_1,
    input  logic                  bus_handshake_2
);

    typedef enum logic [2:0] {
        IDLE,
        DATA_REQ,
        DATA_ACK,
        STAT_REQ,
        STAT_ACK,
        ABORT,
        RESPOND
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_tmo;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_data;
    logic                  r_bus_rw;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [DATA_WIDTH-1:0] r_rsp_status;

    // Gated with the reset input so cmd_ready is low while reset is held, not only after the next edge.
    assign cmd_ready       = (r_state == IDLE) && reset;
    assign w_accept        = cmd_valid && cmd_ready;
    assign rsp_valid       = (r_state == RESPOND);
    assign bus_handshake_1 = (r_state == DATA_REQ) || (r_state == STAT_REQ);
    assign bus_reg_address = r_bus_addr;
    assign bus_data_out    = r_bus_data;
    assign bus_RW          = r_bus_rw;
    assign rsp_data        = r_rsp_data;
    assign rsp_status      = r_rsp_status;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_timeout;

    assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = r_rsp_timeout;

    // Cycles spent in the current state; saturates so idle time cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (!w_tmo) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_accept) begin
            r_rsp_timeout <= 1'b0;
        end else if ((r_state == ABORT) && (w_next == RESPOND)) begin
            r_rsp_timeout <= 1'b1;
        end
    end
`else
    assign w_tmo       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = DATA_REQ;
            end
            DATA_REQ: begin
                if (bus_handshake_2)  w_next = DATA_ACK;
                else if (w_tmo)       w_next = ABORT;
            end
            DATA_ACK: begin
                if (!bus_handshake_2) w_next = STAT_REQ;
                else if (w_tmo)       w_next = ABORT;
            end
            STAT_REQ: begin
                if (bus_handshake_2)  w_next = STAT_ACK;
                else if (w_tmo)       w_next = ABORT;
            end
            STAT_ACK: begin
                if (!bus_handshake_2) w_next = RESPOND;
                else if (w_tmo)       w_next = ABORT;
            end
            ABORT: begin
                if (!bus_handshake_2 || w_tmo) w_next = RESPOND;
            end
            RESPOND: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_addr   <= '0;
            r_bus_data   <= '0;
            r_bus_rw     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
        end else begin
            if (w_accept) begin
                r_bus_addr <= cmd_addr;
                r_bus_data <= cmd_data;
                r_bus_rw   <= cmd_RW;
            end
            // A write echoes its own data word in place of the bus read-back.
            if ((r_state == DATA_REQ) && bus_handshake_2) begin
                r_rsp_data <= r_bus_rw ? bus_data_in : r_bus_data;
            end
            if ((r_state == STAT_REQ) && bus_handshake_2) begin
                r_rsp_status <= bus_data_in;
            end
`ifdef BUS_TIMEOUT_EN
            if ((r_state == ABORT) && (w_next == RESPOND)) begin
                r_rsp_status <= '1;
            end
`endif
        end
    end

endmodule
